// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
// The result is computed at launch and held pending; HI/LO commit when the cycle count expires.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;

    logic        w_is_md;
    logic [63:0] w_smul, w_umul, w_result;
    logic        w_a_neg, w_b_neg, w_div_zero;
    logic [31:0] w_a_abs, w_b_abs, w_q_abs, w_r_abs, w_q, w_r;
    logic [3:0]  w_cnt_init;

    assign w_is_md = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                     (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);

    // Sign-extended 64x64 product truncated to 64 bits equals the signed 32x32 product.
    assign w_smul = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    assign w_umul = {32'd0, rs_data} * {32'd0, rt_data};

    // Signed division on magnitudes avoids the 0x80000000 / -1 overflow corner.
    assign w_a_neg    = (mdu_op == OP_DIV) && rs_data[31];
    assign w_b_neg    = (mdu_op == OP_DIV) && rt_data[31];
    assign w_a_abs    = w_a_neg ? -rs_data : rs_data;
    assign w_b_abs    = w_b_neg ? -rt_data : rt_data;
    assign w_div_zero = (rt_data == 32'd0);
    assign w_q_abs    = w_div_zero ? 32'd0 : w_a_abs / w_b_abs;
    assign w_r_abs    = w_div_zero ? 32'd0 : w_a_abs % w_b_abs;
    assign w_q        = (w_a_neg ^ w_b_neg) ? -w_q_abs : w_q_abs;
    assign w_r        = w_a_neg ? -w_r_abs : w_r_abs;

    always_comb begin
        w_result   = {r_hi, r_lo};
        w_cnt_init = 4'd5;
        case (mdu_op)
            OP_MULT:  w_result = w_smul;
            OP_MULTU: w_result = w_umul;
            OP_DIV, OP_DIVU: begin
                w_cnt_init = 4'd10;
                // Divide by zero recommits the current HI/LO, leaving them unchanged.
                w_result   = w_div_zero ? {r_hi, r_lo} : {w_r, w_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && w_is_md) begin
                        r_pend_hi <= w_result[63:32];
                        r_pend_lo <= w_result[31:0];
                        r_cnt     <= w_cnt_init;
                        r_state   <= BUSY;
                    end else if (start && mdu_op == OP_MTHI) begin
                        r_hi <= rs_data;
                    end else if (start && mdu_op == OP_MTLO) begin
                        r_lo <= rs_data;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = (r_state == BUSY);
    assign stall_req = busy || (start && w_is_md);
    assign rd_data   = rd_sel ? r_hi : r_lo;
    assign hi_out    = r_hi;
    assign lo_out    = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        reset, start, rd_sel;
    logic [2:0]  mdu_op;
    logic [31:0] rs_data, rt_data;
    logic [31:0] rd_data, hi_out, lo_out;
    logic        busy, stall_req;
    int          checks = 0;
    int          errors = 0;

    mul_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .rs_data(rs_data), .rt_data(rt_data), .rd_sel(rd_sel),
        .rd_data(rd_data), .busy(busy), .stall_req(stall_req),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start pulse; returns #1 after the launch edge.
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        @(negedge clk);
        start = 1'b1; mdu_op = op; rs_data = a; rt_data = b;
        #1 check({tag, "_stall"}, stall_req, (op >= 3'd1 && op <= 3'd4));
        @(posedge clk); #1;
        start = 1'b0; mdu_op = 3'd0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_cycles, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input string tag);
        int n;
        launch(op, a, b, tag);
        n = 0;
        while (busy && n < 30) begin
            n++;
            @(posedge clk); #1;
        end
        check({tag, "_cycles"}, n, exp_cycles);
        check({tag, "_hi"}, hi_out, exp_hi);
        check({tag, "_lo"}, lo_out, exp_lo);
        rd_sel = 1'b1;
        #1 check({tag, "_rd_hi"}, rd_data, exp_hi);
        rd_sel = 1'b0;
        #1 check({tag, "_rd_lo"}, rd_data, exp_lo);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mdu_op = 3'd0;
        rs_data = 32'd0; rt_data = 32'd0; rd_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        check("rst_rd", rd_data, 0);
        check("rst_stall", stall_req, 0);
        // Start during reset: stall follows start combinationally, but nothing launches.
        start = 1'b1; mdu_op = 3'd3; rs_data = 32'd9; rt_data = 32'd2;
        #1 check("rst_stall_comb", stall_req, 1);
        @(posedge clk); #1;
        check("rst_no_launch", busy, 0);
        start = 1'b0; mdu_op = 3'd0;
        @(negedge clk);
        reset = 1'b1;

        run_op(3'd6, 32'h0000_1234, 32'd0, 0, 32'h0, 32'h0000_1234, "mtlo");
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        run_op(3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3, "divu");
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, "div_ovf");
        run_op(3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD, "div_negb");
        run_op(3'd1, 32'h0001_0000, 32'hFFFF_0000, 5, 32'hFFFF_FFFF, 32'h0, "mult_mix");
        run_op(3'd5, 32'hAAAA_0000, 32'd0, 0, 32'hAAAA_0000, 32'h0, "mthi");
        run_op(3'd6, 32'h0000_BBBB, 32'd0, 0, 32'hAAAA_0000, 32'h0000_BBBB, "mtlo2");
        run_op(3'd4, 32'd123, 32'd0, 10, 32'hAAAA_0000, 32'h0000_BBBB, "divu_zero");
        run_op(3'd0, 32'h5555_5555, 32'd3, 0, 32'hAAAA_0000, 32'h0000_BBBB, "op_none");
        run_op(3'd7, 32'h5555_5555, 32'd3, 0, 32'hAAAA_0000, 32'h0000_BBBB, "op_rsvd");

        // Starts while busy are ignored; HI/LO stay architectural until commit.
        launch(3'd1, 32'd3, 32'd5, "ign");
        check("ign_busy1", busy, 1);
        @(posedge clk); #1;
        start = 1'b1; mdu_op = 3'd6; rs_data = 32'h0000_1234;
        #1 check("ign_stall2", stall_req, 1);
        @(posedge clk); #1;
        mdu_op = 3'd3; rs_data = 32'd100; rt_data = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; mdu_op = 3'd0;
        check("ign_busy4", busy, 1);
        check("ign_rd_old", rd_data, 32'h0000_BBBB);
        @(posedge clk); #1;
        check("ign_busy5", busy, 1);
        @(posedge clk); #1;
        check("ign_done", busy, 0);
        check("ign_hi", hi_out, 32'd0);
        check("ign_lo", lo_out, 32'd15);

        // Reset mid-divide discards the pending result.
        launch(3'd3, 32'd100, 32'd7, "rstdiv");
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstdiv_busy3", busy, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("rstdiv_busy", busy, 0);
        check("rstdiv_hi", hi_out, 0);
        check("rstdiv_lo", lo_out, 0);
        repeat (8) @(posedge clk);
        #1;
        check("rstdiv_late_busy", busy, 0);
        check("rstdiv_late_hi", hi_out, 0);
        check("rstdiv_late_lo", lo_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
